// File: rtl/sprite_anim_engine_if.sv
// rtl/sprite_anim_engine_if.sv - animation request bus between game logic and sprite engine (option: SPRITE_HFLIP_EN)
interface sprite_anim_engine_if #(
    parameter int NUM_TYPES  = 3,
    parameter int NUM_FRAMES = 5
);
    localparam int TYPE_W  = (NUM_TYPES  > 1) ? $clog2(NUM_TYPES)  : 1;
    localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    logic               anim_req;
    logic [1:0]         anim_mode;
    logic [TYPE_W-1:0]  ship_type;
`ifdef SPRITE_HFLIP_EN
    logic               facing_left;
`endif
    logic               anim_ack;
    logic               anim_done;
    logic [FRAME_W-1:0] anim_frame;

`ifdef SPRITE_HFLIP_EN
    modport master (output anim_req, anim_mode, ship_type, facing_left,
                    input  anim_ack, anim_done, anim_frame);
    modport slave  (input  anim_req, anim_mode, ship_type, facing_left,
                    output anim_ack, anim_done, anim_frame);
`else
    modport master (output anim_req, anim_mode, ship_type,
                    input  anim_ack, anim_done, anim_frame);
    modport slave  (input  anim_req, anim_mode, ship_type,
                    output anim_ack, anim_done, anim_frame);
`endif
endinterface

// File: rtl/sprite_anim_engine.sv
// rtl/sprite_anim_engine.sv - sprite renderer with animation sequencer (option: SPRITE_HFLIP_EN)
module sprite_anim_engine #(
    parameter int SPRITE_W        = 80,
    parameter int SPRITE_H        = 80,
    parameter int NUM_TYPES       = 3,
    parameter int NUM_FRAMES      = 5,
    parameter int FRAME_HOLD      = 6,
    parameter int ADDR_W          = 19,
    parameter int DATA_W          = 4,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_clk,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic [9:0]          Pos_X,
    input  logic [9:0]          Pos_Y,
    sprite_anim_engine_if.slave anim_bus,
    output logic [ADDR_W-1:0]   read_address,
    input  logic [DATA_W-1:0]   rom_data,
    output logic                is_sprite,
    output logic [DATA_W-1:0]   pixel_data
);
    localparam int TYPE_W  = (NUM_TYPES  > 1) ? $clog2(NUM_TYPES)  : 1;
    localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int HOLD_W  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    localparam logic [FRAME_W-1:0] LP_LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  LP_LAST_HOLD  = HOLD_W'(FRAME_HOLD - 1);
    localparam logic signed [10:0] LP_W      = 11'(SPRITE_W);
    localparam logic signed [10:0] LP_H      = 11'(SPRITE_H);
    localparam logic signed [10:0] LP_HALF_W = 11'(SPRITE_W / 2);
    localparam logic signed [10:0] LP_HALF_H = 11'(SPRITE_H / 2);

    typedef enum logic [1:0] {
        S_STAND = 2'd0,
        S_LOOP  = 2'd1,
        S_ONCE  = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [FRAME_W-1:0]  r_frame, w_frame_nxt;
    logic [HOLD_W-1:0]   r_hold,  w_hold_nxt;
    logic [TYPE_W-1:0]   r_type,  w_type_nxt;
    logic [TYPE_W-1:0]   r_dtype;
    logic [FRAME_W-1:0]  r_dframe;
    logic                r_ack, r_done, w_done_nxt;
    logic                r_frame_clk_q;
    logic                w_tick, w_accept;
    logic                r_inbox_d1, r_inbox_d2;
    logic signed [10:0]  w_lx, w_ly, w_lx_addr;
    logic                w_inbox;
    logic [ADDR_W-1:0]   w_img, w_addr;

    assign w_tick = frame_clk & ~r_frame_clk_q;

    // Edge detector for the frame strobe
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_frame_clk_q <= 1'b0;
        else          r_frame_clk_q <= frame_clk;
    end

    // Request acceptance: ONCE may only be pre-empted by DEAD, DEAD is terminal
    always_comb begin
        w_accept = 1'b0;
        if (anim_bus.anim_req) begin
            case (r_state)
                S_STAND, S_LOOP: w_accept = 1'b1;
                S_ONCE:          w_accept = (anim_bus.anim_mode == 2'd3);
                default:         w_accept = 1'b0;
            endcase
        end
    end

    // Next state: accept wins over a coincident tick, otherwise hold/frame advance
    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_hold_nxt  = r_hold;
        w_type_nxt  = r_type;
        w_done_nxt  = 1'b0;
        if (w_accept) begin
            w_state_nxt = state_t'(anim_bus.anim_mode);
            w_frame_nxt = '0;
            w_hold_nxt  = '0;
            w_type_nxt  = anim_bus.ship_type;
        end else if (w_tick) begin
            if (r_hold < LP_LAST_HOLD) begin
                w_hold_nxt = r_hold + HOLD_W'(1);
            end else begin
                w_hold_nxt = '0;
                case (r_state)
                    S_STAND: w_frame_nxt = '0;
                    S_LOOP:  w_frame_nxt = (r_frame == LP_LAST_FRAME) ? '0 : r_frame + FRAME_W'(1);
                    S_ONCE: begin
                        if (r_frame == LP_LAST_FRAME) begin
                            w_state_nxt = S_STAND;
                            w_frame_nxt = '0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_frame_nxt = r_frame + FRAME_W'(1);
                        end
                    end
                    default: begin
                        if (r_frame != LP_LAST_FRAME) w_frame_nxt = r_frame + FRAME_W'(1);
                    end
                endcase
            end
        end
    end

    // Animation state register and handshake pulses
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_STAND;
            r_frame <= '0;
            r_hold  <= '0;
            r_type  <= '0;
            r_ack   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_frame <= w_frame_nxt;
            r_hold  <= w_hold_nxt;
            r_type  <= w_type_nxt;
            r_ack   <= w_accept;
            r_done  <= w_done_nxt;
        end
    end

    // Display shadow only moves on a tick so a frame never changes mid-scan
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_dtype  <= '0;
            r_dframe <= '0;
        end else if (w_tick && !w_accept) begin
            r_dtype  <= r_type;
            r_dframe <= r_frame;
        end
    end

`ifdef SPRITE_HFLIP_EN
    logic r_face, r_dface;

    // Facing direction follows the same latch/shadow path as ship type
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_face  <= 1'b0;
            r_dface <= 1'b0;
        end else begin
            if (w_accept)             r_face  <= anim_bus.facing_left;
            if (w_tick && !w_accept)  r_dface <= r_face;
        end
    end

    assign w_lx_addr = r_dface ? (LP_W - 11'sd1 - w_lx) : w_lx;
`else
    assign w_lx_addr = w_lx;
`endif

    assign anim_bus.anim_ack   = r_ack;
    assign anim_bus.anim_done  = r_done;
    assign anim_bus.anim_frame = r_frame;

    // 11-bit signed local coordinates; left/top clipping falls out as negative values
    assign w_lx    = $signed({1'b0, DrawX}) - $signed({1'b0, Pos_X}) + LP_HALF_W;
    assign w_ly    = $signed({1'b0, DrawY}) - $signed({1'b0, Pos_Y}) + LP_HALF_H;
    assign w_inbox = (w_lx >= 11'sd0) && (w_lx < LP_W) && (w_ly >= 11'sd0) && (w_ly < LP_H);
    assign w_img   = ADDR_W'(r_dtype) * ADDR_W'(NUM_FRAMES) + ADDR_W'(r_dframe);
    assign w_addr  = w_img * ADDR_W'(SPRITE_W * SPRITE_H)
                   + ADDR_W'($unsigned(w_ly)) * ADDR_W'(SPRITE_W)
                   + ADDR_W'($unsigned(w_lx_addr));

    // Pixel pipeline: address at +1, ROM data at +2, colour/opacity at +3
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address <= '0;
            r_inbox_d1   <= 1'b0;
            r_inbox_d2   <= 1'b0;
            pixel_data   <= '0;
            is_sprite    <= 1'b0;
        end else begin
            read_address <= w_inbox ? w_addr : '0;
            r_inbox_d1   <= w_inbox;
            r_inbox_d2   <= r_inbox_d1;
            pixel_data   <= r_inbox_d2 ? rom_data : '0;
            is_sprite    <= r_inbox_d2 && (rom_data != DATA_W'(TRANSPARENT_IDX));
        end
    end
endmodule
